// File: rtl/cpu_bus_bridge.sv
// rtl/cpu_bus_bridge.sv - address-decoding bridge from the CPU memory port to RAM and the req/ack IO bus
// Low addresses go straight to the RAM; the IO window stalls the CPU around one bus transaction.
module cpu_bus_bridge #(
   parameter logic [15:0] IO_BASE = 16'hFF00,
   parameter int          TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] cpu_address,
   input  logic [31:0] cpu_data,
   input  logic        cpu_wren,
   output logic [31:0] cpu_q,
   output logic        cpu_stall,
   output logic [15:0] ram_address,
   output logic [31:0] ram_data,
   output logic        ram_wren,
   input  logic [31:0] ram_q,
   output logic [7:0]  io_address,
   output logic [31:0] io_wdata,
   output logic        io_we,
   output logic        io_req,
   input  logic        io_ack,
   input  logic [31:0] io_rdata,
   output logic        bus_error
);

   // The counter only ever reaches TIMEOUT-1.
   localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      IO_WAIT = 2'd1,
      IO_DONE = 2'd2
   } state_t;

   state_t         state, state_nx;
   logic [CW-1:0]  cnt, cnt_nx;
   logic [31:0]    rdata, rdata_nx;
   logic [7:0]     io_address_nx;
   logic [31:0]    io_wdata_nx;
   logic           io_we_nx;
   logic           io_req_nx;
   logic           bus_error_nx;
   logic           io_hit;

   assign io_hit = (cpu_address >= IO_BASE);

   assign ram_address = cpu_address;
   assign ram_data    = cpu_data;
   assign ram_wren    = cpu_wren & ~io_hit;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= '0;
         rdata      <= '0;
         io_address <= '0;
         io_wdata   <= '0;
         io_we      <= 1'b0;
         io_req     <= 1'b0;
         bus_error  <= 1'b0;
      end else begin
         state      <= state_nx;
         cnt        <= cnt_nx;
         rdata      <= rdata_nx;
         io_address <= io_address_nx;
         io_wdata   <= io_wdata_nx;
         io_we      <= io_we_nx;
         io_req     <= io_req_nx;
         bus_error  <= bus_error_nx;
      end
   end

   always_comb begin
      state_nx      = state;
      cnt_nx        = cnt;
      rdata_nx      = rdata;
      io_address_nx = io_address;
      io_wdata_nx   = io_wdata;
      io_we_nx      = io_we;
      io_req_nx     = io_req;
      bus_error_nx  = bus_error;
      cpu_stall     = 1'b0;
      cpu_q         = ram_q;

      case (state)
         IDLE: begin
            cpu_stall = io_hit;
            if (io_hit) begin
               io_address_nx = cpu_address[7:0];
               io_wdata_nx   = cpu_data;
               io_we_nx      = cpu_wren;
               io_req_nx     = 1'b1;
               cnt_nx        = '0;
               state_nx      = IO_WAIT;
            end
         end
         IO_WAIT: begin
            cpu_stall = 1'b1;
            // Ack takes priority over a timeout landing in the same cycle.
            if (io_ack) begin
               rdata_nx  = io_rdata;
               io_req_nx = 1'b0;
               state_nx  = IO_DONE;
            end else if (cnt == CNT_LAST) begin
               rdata_nx     = 32'hDEADBEEF;
               bus_error_nx = 1'b1;
               io_req_nx    = 1'b0;
               state_nx     = IO_DONE;
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end
         IO_DONE: begin
            // CPU still presents the finished IO address here; never restart on it.
            cpu_q    = rdata;
            state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_cpu_bus_bridge.sv
// tb/tb_cpu_bus_bridge.sv - directed self-checking bench for cpu_bus_bridge
module tb_cpu_bus_bridge;

   logic        clk;
   logic        reset;
   logic [15:0] cpu_address;
   logic [31:0] cpu_data;
   logic        cpu_wren;
   logic [31:0] cpu_q;
   logic        cpu_stall;
   logic [15:0] ram_address;
   logic [31:0] ram_data;
   logic        ram_wren;
   logic [31:0] ram_q;
   logic [7:0]  io_address;
   logic [31:0] io_wdata;
   logic        io_we;
   logic        io_req;
   logic        io_ack;
   logic [31:0] io_rdata;
   logic        bus_error;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] mem [0:255];

   cpu_bus_bridge #(.IO_BASE(16'hFF00), .TIMEOUT(4)) dut (
      .clk         (clk),
      .reset       (reset),
      .cpu_address (cpu_address),
      .cpu_data    (cpu_data),
      .cpu_wren    (cpu_wren),
      .cpu_q       (cpu_q),
      .cpu_stall   (cpu_stall),
      .ram_address (ram_address),
      .ram_data    (ram_data),
      .ram_wren    (ram_wren),
      .ram_q       (ram_q),
      .io_address  (io_address),
      .io_wdata    (io_wdata),
      .io_we       (io_we),
      .io_req      (io_req),
      .io_ack      (io_ack),
      .io_rdata    (io_rdata),
      .bus_error   (bus_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Registered-address RAM, one cycle read latency.
   always @(posedge clk) begin
      if (ram_wren) mem[ram_address[7:0]] <= ram_data;
      ram_q <= mem[ram_address[7:0]];
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      reset = 1'b1;
      cpu_address = 16'h0000;
      cpu_wren = 1'b0;
      io_ack = 1'b0;
      tick;
      tick;
      reset = 1'b0;
   endtask

   // Drives one IO access until IO_DONE and reports what was seen; ack_at < 0 means no ack.
   task automatic run_io(input logic [15:0] addr, input logic [31:0] wd, input logic wr,
                         input logic [31:0] rd, input int ack_at,
                         output int stall_n, output int req_n, output logic [31:0] q,
                         output logic done, output logic ramw, output logic [7:0] ia,
                         output logic iwe, output logic [31:0] iwd, output logic stable);
      logic first;
      cpu_address = addr;
      cpu_data = wd;
      cpu_wren = wr;
      io_rdata = rd;
      stall_n = 0;
      req_n = 0;
      q = '0;
      done = 1'b0;
      ramw = 1'b0;
      stable = 1'b1;
      first = 1'b1;
      ia = '0;
      iwe = 1'b0;
      iwd = '0;
      for (int c = 0; c < 20 && !done; c++) begin
         io_ack = (c == ack_at);
         #1;
         if (cpu_stall) stall_n++;
         if (ram_wren) ramw = 1'b1;
         if (io_req) begin
            req_n++;
            if (first) begin
               ia = io_address;
               iwe = io_we;
               iwd = io_wdata;
               first = 1'b0;
            end else if (ia !== io_address || iwe !== io_we || iwd !== io_wdata) begin
               stable = 1'b0;
            end
         end
         if (!cpu_stall && c > 0) begin
            done = 1'b1;
            q = cpu_q;
            cpu_address = 16'h0000;
            cpu_wren = 1'b0;
            io_ack = 1'b0;
         end
         tick;
      end
      io_ack = 1'b0;
      cpu_address = 16'h0000;
      cpu_wren = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      cpu_address = 16'hFF00;
      cpu_data = 32'h0;
      cpu_wren = 1'b0;
      io_ack = 1'b0;
      io_rdata = 32'h0;
      tick;
      tick;
      n_checks++;
      if (cpu_stall !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_stall_io_addr: got %b expected 1", cpu_stall);
      end
      cpu_address = 16'h0000;
      tick;
      reset = 1'b0;
      #1;
      n_checks++;
      if ({io_req, io_we, io_address, io_wdata, bus_error, cpu_stall} !== 43'h0) begin
         n_fail++;
         $display("FAIL reset_values: req=%b we=%b addr=%h wdata=%h err=%b stall=%b expected all zero",
                  io_req, io_we, io_address, io_wdata, bus_error, cpu_stall);
      end
      tick;
   endtask

   task automatic test_ram;
      logic stall_seen;
      stall_seen = 1'b0;
      cpu_address = 16'h0000;
      cpu_data = 32'h11111111;
      cpu_wren = 1'b1;
      tick;
      cpu_address = 16'h0010;
      cpu_data = 32'h12345678;
      cpu_wren = 1'b1;
      #1;
      if (cpu_stall) stall_seen = 1'b1;
      n_checks++;
      if (ram_wren !== 1'b1 || ram_address !== 16'h0010 || ram_data !== 32'h12345678) begin
         n_fail++;
         $display("FAIL ram_write_port: wren=%b addr=%h data=%h expected 1 0010 12345678",
                  ram_wren, ram_address, ram_data);
      end
      tick;
      cpu_wren = 1'b0;
      #1;
      if (cpu_stall) stall_seen = 1'b1;
      n_checks++;
      if (ram_wren !== 1'b0) begin
         n_fail++;
         $display("FAIL ram_wren_one_cycle: got %b expected 0", ram_wren);
      end
      tick;
      #1;
      if (cpu_stall) stall_seen = 1'b1;
      n_checks++;
      if (cpu_q !== 32'h12345678) begin
         n_fail++;
         $display("FAIL ram_readback: got %h expected 12345678", cpu_q);
      end
      n_checks++;
      if (stall_seen !== 1'b0) begin
         n_fail++;
         $display("FAIL ram_no_stall: got %b expected 0", stall_seen);
      end
      cpu_address = 16'h0000;
      tick;
   endtask

   task automatic test_io_read;
      int sn, rn;
      logic [31:0] q, iwd;
      logic done, ramw, iwe, stable;
      logic [7:0] ia;
      run_io(16'hFF04, 32'h0, 1'b0, 32'hCAFE0001, 3, sn, rn, q, done, ramw, ia, iwe, iwd, stable);
      n_checks++;
      if (done !== 1'b1 || q !== 32'hCAFE0001) begin
         n_fail++;
         $display("FAIL io_read_data: done=%b q=%h expected 1 CAFE0001", done, q);
      end
      n_checks++;
      if (sn != 4 || rn != 3) begin
         n_fail++;
         $display("FAIL io_read_timing: stall=%0d req=%0d expected 4 3", sn, rn);
      end
      n_checks++;
      if (ia !== 8'h04 || iwe !== 1'b0 || stable !== 1'b1) begin
         n_fail++;
         $display("FAIL io_read_latch: addr=%h we=%b stable=%b expected 04 0 1", ia, iwe, stable);
      end
      n_checks++;
      if (bus_error !== 1'b0) begin
         n_fail++;
         $display("FAIL io_read_no_error: got %b expected 0", bus_error);
      end
   endtask

   task automatic test_io_write;
      int sn, rn;
      logic [31:0] q, iwd;
      logic done, ramw, iwe, stable;
      logic [7:0] ia;
      run_io(16'hFF10, 32'hA5A5A5A5, 1'b1, 32'h0, 1, sn, rn, q, done, ramw, ia, iwe, iwd, stable);
      n_checks++;
      if (iwe !== 1'b1 || iwd !== 32'hA5A5A5A5 || ia !== 8'h10) begin
         n_fail++;
         $display("FAIL io_write_latch: we=%b wdata=%h addr=%h expected 1 A5A5A5A5 10", iwe, iwd, ia);
      end
      n_checks++;
      if (ramw !== 1'b0) begin
         n_fail++;
         $display("FAIL io_write_no_ram: got %b expected 0", ramw);
      end
      n_checks++;
      if (done !== 1'b1 || sn != 2 || rn != 1) begin
         n_fail++;
         $display("FAIL io_write_timing: done=%b stall=%0d req=%0d expected 1 2 1", done, sn, rn);
      end
   endtask

   task automatic test_timeout;
      int sn, rn;
      logic [31:0] q, iwd;
      logic done, ramw, iwe, stable;
      logic [7:0] ia;
      run_io(16'hFF20, 32'h0, 1'b0, 32'h55555555, -1, sn, rn, q, done, ramw, ia, iwe, iwd, stable);
      n_checks++;
      if (done !== 1'b1 || q !== 32'hDEADBEEF) begin
         n_fail++;
         $display("FAIL timeout_data: done=%b q=%h expected 1 DEADBEEF", done, q);
      end
      n_checks++;
      if (rn != 4 || sn != 5) begin
         n_fail++;
         $display("FAIL timeout_timing: req=%0d stall=%0d expected 4 5", rn, sn);
      end
      n_checks++;
      if (bus_error !== 1'b1) begin
         n_fail++;
         $display("FAIL timeout_error_set: got %b expected 1", bus_error);
      end
      run_io(16'hFF24, 32'h0, 1'b0, 32'h00000024, 1, sn, rn, q, done, ramw, ia, iwe, iwd, stable);
      tick;
      n_checks++;
      if (bus_error !== 1'b1 || q !== 32'h00000024) begin
         n_fail++;
         $display("FAIL timeout_error_sticky: err=%b q=%h expected 1 00000024", bus_error, q);
      end
      do_reset;
      #1;
      n_checks++;
      if (bus_error !== 1'b0) begin
         n_fail++;
         $display("FAIL timeout_error_cleared: got %b expected 0", bus_error);
      end
   endtask

   task automatic test_ack_on_timeout;
      int sn, rn;
      logic [31:0] q, iwd;
      logic done, ramw, iwe, stable;
      logic [7:0] ia;
      do_reset;
      run_io(16'hFF30, 32'h0, 1'b0, 32'h13572468, 4, sn, rn, q, done, ramw, ia, iwe, iwd, stable);
      n_checks++;
      if (done !== 1'b1 || q !== 32'h13572468) begin
         n_fail++;
         $display("FAIL ack_on_timeout_data: done=%b q=%h expected 1 13572468", done, q);
      end
      n_checks++;
      if (bus_error !== 1'b0 || rn != 4) begin
         n_fail++;
         $display("FAIL ack_on_timeout_error: err=%b req=%0d expected 0 4", bus_error, rn);
      end
   endtask

   task automatic test_back_to_back;
      logic [5:0] exp_stall, exp_req, got_stall, got_req;
      exp_stall = 6'b011011;
      exp_req   = 6'b010010;
      got_stall = '0;
      got_req = '0;
      cpu_address = 16'hFF04;
      cpu_wren = 1'b0;
      io_rdata = 32'h0B0B0B0B;
      for (int c = 0; c < 6; c++) begin
         io_ack = (c == 1 || c == 4);
         if (c == 5) cpu_address = 16'h0000;
         #1;
         got_stall[c] = cpu_stall;
         got_req[c] = io_req;
         tick;
      end
      io_ack = 1'b0;
      n_checks++;
      if (got_stall !== exp_stall || got_req !== exp_req) begin
         n_fail++;
         $display("FAIL back_to_back: stall=%b req=%b expected %b %b (bit0 first cycle)",
                  got_stall, got_req, exp_stall, exp_req);
      end
   endtask

   task automatic test_reset_mid;
      cpu_address = 16'hFF40;
      cpu_wren = 1'b0;
      io_ack = 1'b0;
      tick;
      tick;
      #1;
      n_checks++;
      if (io_req !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_mid_setup: req=%b expected 1", io_req);
      end
      reset = 1'b1;
      cpu_address = 16'h0000;
      tick;
      reset = 1'b0;
      #1;
      n_checks++;
      if (io_req !== 1'b0 || cpu_stall !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid_abort: req=%b stall=%b expected 0 0", io_req, cpu_stall);
      end
      tick;
      io_rdata = 32'hBADBAD00;
      io_ack = 1'b1;
      tick;
      io_ack = 1'b0;
      #1;
      n_checks++;
      if (io_req !== 1'b0 || cpu_stall !== 1'b0 || cpu_q !== 32'h11111111) begin
         n_fail++;
         $display("FAIL reset_mid_late_ack: req=%b stall=%b q=%h expected 0 0 11111111",
                  io_req, cpu_stall, cpu_q);
      end
   endtask

   initial begin
      reset = 1'b1;
      cpu_address = 16'h0000;
      cpu_data = 32'h0;
      cpu_wren = 1'b0;
      io_ack = 1'b0;
      io_rdata = 32'h0;
      test_reset;
      test_ram;
      test_io_read;
      test_io_write;
      test_back_to_back;
      test_timeout;
      test_ack_on_timeout;
      test_reset_mid;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
